mult_div_unit: RTL

- Iterative multiply/divide unit with HI/LO result registers, sitting directly downstream of the register file beside the ALU.
- Consumes ReadData1/ReadData2 for MULT, MULTU, DIV and DIVU, and supports MTHI/MTLO.
- Supplies HI/LO back to the write-back mux for MFHI/MFLO.
- Raises Busy so the control unit can stall the PC while an operation runs.

---
 rtl/mult_div_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// Signed operations run on magnitudes; signs are restored in a final FIX cycle.
module mult_div_unit #(
  parameter int NBits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [NBits-1:0] OperandA,
  input  logic [NBits-1:0] OperandB,
  input  logic             HIWrite,
  input  logic             LOWrite,
  input  logic [NBits-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic [NBits-1:0] HI,
  output logic [NBits-1:0] LO
);

  localparam int CW = (NBits > 1) ? $clog2(NBits) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBits - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_op;
  logic             r_neg_a;
  logic             r_neg_b;
  logic [NBits-1:0] r_a;
  logic [NBits-1:0] r_b;
  logic [NBits-1:0] r_acc;
  logic [NBits-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic [NBits-1:0] r_hi;
  logic [NBits-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  logic             w_neg_a_in;
  logic             w_neg_b_in;
  logic [NBits-1:0] w_abs_a_in;
  logic [NBits-1:0] w_abs_b_in;
  logic [NBits:0]   w_add;
  logic [NBits:0]   w_shift;
  logic [NBits+1:0] w_diff;
  logic             w_nob;
  logic [2*NBits-1:0] w_prod;
  logic [2*NBits-1:0] w_prod_fix;
  logic [NBits-1:0] w_quot_fix;
  logic [NBits-1:0] w_rem_fix;
  logic [NBits-1:0] w_a_raw;
  logic             w_b_zero;

  // Operand magnitudes: the most negative value negates to itself, i.e. 2^(NBits-1) unsigned.
  assign w_neg_a_in = Op[0] & OperandA[NBits-1];
  assign w_neg_b_in = Op[0] & OperandB[NBits-1];
  assign w_abs_a_in = w_neg_a_in ? -OperandA : OperandA;
  assign w_abs_b_in = w_neg_b_in ? -OperandB : OperandB;

  assign w_add   = r_q[0] ? ({1'b0, r_acc} + {1'b0, r_a}) : {1'b0, r_acc};
  assign w_shift = {r_acc, r_q[NBits-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_b};
  assign w_nob   = ~w_diff[NBits+1];

  assign w_prod     = {r_acc, r_q};
  assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
  assign w_quot_fix = (r_neg_a ^ r_neg_b) ? -r_q : r_q;
  assign w_rem_fix  = r_neg_a ? -r_acc : r_acc;
  assign w_a_raw    = r_neg_a ? -r_a : r_a;
  assign w_b_zero   = (r_b == {NBits{1'b0}});

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_next = ST_RUN;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt == LAST) begin
          w_next = ST_FIX;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_FIX:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath, HI/LO and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op    <= 2'b00;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_a     <= {NBits{1'b0}};
      r_b     <= {NBits{1'b0}};
      r_acc   <= {NBits{1'b0}};
      r_q     <= {NBits{1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_hi    <= {NBits{1'b0}};
      r_lo    <= {NBits{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_op    <= Op;
            r_neg_a <= w_neg_a_in;
            r_neg_b <= w_neg_b_in;
            r_a     <= w_abs_a_in;
            r_b     <= w_abs_b_in;
            r_acc   <= {NBits{1'b0}};
            // Multiply shifts the multiplier out of r_q; divide shifts the dividend out of it.
            r_q     <= Op[1] ? w_abs_a_in : w_abs_b_in;
            r_cnt   <= {CW{1'b0}};
            r_busy  <= 1'b1;
          end else begin
            if (HIWrite) begin
              r_hi <= WriteData;
            end else begin
              r_hi <= r_hi;
            end
            if (LOWrite) begin
              r_lo <= WriteData;
            end else begin
              r_lo <= r_lo;
            end
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          if (r_op[1]) begin
            r_acc <= w_nob ? w_diff[NBits-1:0] : w_shift[NBits-1:0];
            r_q   <= {r_q[NBits-2:0], w_nob};
          end else begin
            r_acc <= w_add[NBits:1];
            r_q   <= {w_add[0], r_q[NBits-1:1]};
          end
        end
        ST_FIX: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (!r_op[1]) begin
            r_hi <= w_prod_fix[2*NBits-1:NBits];
            r_lo <= w_prod_fix[NBits-1:0];
          end else if (w_b_zero) begin
            r_hi <= w_a_raw;
            r_lo <= {NBits{1'b1}};
          end else begin
            r_hi <= w_rem_fix;
            r_lo <= w_quot_fix;
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = r_busy;
  assign Done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
